// File: rtl/mul2x2_sched.sv
// Computes a WIDTH x WIDTH unsigned product by time-sharing one external 2x2-bit
// multiplier, issuing one 2-bit digit pair per cycle and accumulating shifted partials.
module mul2x2_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           mul_a_n,
  output logic [1:0]           mul_b_n,
  input  logic [3:0]           mul_p
);

  localparam int unsigned D  = WIDTH / 2;
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = IW + 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]  i_q, i_d, j_q, j_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic           busy_d, done_d;
  logic [PW-1:0]  product_d;
  logic [1:0]     mul_a_d, mul_b_d;
  logic [WIDTH-1:0] a_sh, b_sh;

  logic           last_c;
  logic [SW-1:0]  shamt_c;
  logic [PW-1:0]  term_c;

  // Partial product weighted by 4^(i+j)
  assign last_c  = (i_q == IW'(D - 1)) && (j_q == IW'(D - 1));
  assign shamt_c = ({2'b00, i_q} + {2'b00, j_q}) << 1;
  assign term_c  = PW'(mul_p) << shamt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mul_a_n <= 2'b11;
      mul_b_n <= 2'b11;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      busy    <= busy_d;
      done    <= done_d;
      product <= product_d;
      mul_a_n <= mul_a_d;
      mul_b_n <= mul_b_d;
    end
  end

  // Next-state, datapath and registered digit buses (digits for the upcoming cycle)
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    busy_d    = busy;
    done_d    = 1'b0;
    product_d = product;
    mul_a_d   = mul_a_n;
    mul_b_d   = mul_b_n;
    a_sh      = '0;
    b_sh      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
          mul_a_d = ~op_a[1:0];
          mul_b_d = ~op_b[1:0];
        end
      end
      RUN: begin
        acc_d = acc_q + term_c;
        if (last_c) begin
          product_d = acc_q + term_c;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
          mul_a_d   = 2'b11;
          mul_b_d   = 2'b11;
        end else begin
          if (j_q == IW'(D - 1)) begin
            j_d = '0;
            i_d = i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
          a_sh    = a_q >> {i_d, 1'b0};
          b_sh    = b_q >> {j_d, 1'b0};
          mul_a_d = ~a_sh[1:0];
          mul_b_d = ~b_sh[1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul2x2_sched.sv
// Directed bench for mul2x2_sched: WIDTH=4 handshake/bus/reset cases, plus
// WIDTH=2 and WIDTH=8 instances for the a*b sweep.
module tb_mul2x2_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=2 instance
  logic start2; logic [1:0] a2, b2; logic busy2, done2; logic [3:0] prod2;
  logic [1:0] ma2, mb2, da2, db2; logic [3:0] mp2;
  // WIDTH=4 instance
  logic start4; logic [3:0] a4, b4; logic busy4, done4; logic [7:0] prod4;
  logic [1:0] ma4, mb4, da4, db4; logic [3:0] mp4;
  // WIDTH=8 instance
  logic start8; logic [7:0] a8, b8; logic busy8, done8; logic [15:0] prod8;
  logic [1:0] ma8, mb8, da8, db8; logic [3:0] mp8;

  // Shared 2x2 multiplier models (negative-logic digit inputs)
  assign da2 = ~ma2; assign db2 = ~mb2; assign mp2 = {2'b00, da2} * {2'b00, db2};
  assign da4 = ~ma4; assign db4 = ~mb4; assign mp4 = {2'b00, da4} * {2'b00, db4};
  assign da8 = ~ma8; assign db8 = ~mb8; assign mp8 = {2'b00, da8} * {2'b00, db8};

  mul2x2_sched #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .op_a(a2), .op_b(b2),
    .busy(busy2), .done(done2), .product(prod2), .mul_a_n(ma2), .mul_b_n(mb2), .mul_p(mp2));
  mul2x2_sched #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .op_a(a4), .op_b(b4),
    .busy(busy4), .done(done4), .product(prod4), .mul_a_n(ma4), .mul_b_n(mb4), .mul_p(mp4));
  mul2x2_sched #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8),
    .busy(busy8), .done(done8), .product(prod8), .mul_a_n(ma8), .mul_b_n(mb8), .mul_p(mp8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    case (w)
      2:       begin start2 = s; a2 = a[1:0]; b2 = b[1:0]; end
      4:       begin start4 = s; a4 = a[3:0]; b4 = b[3:0]; end
      default: begin start8 = s; a8 = a;      b8 = b;      end
    endcase
  endtask

  // {busy, done, product} of the selected instance
  function automatic logic [17:0] obs(input int w);
    case (w)
      2:       return {busy2, done2, 12'd0, prod2};
      4:       return {busy4, done4, 8'd0, prod4};
      default: return {busy8, done8, prod8};
    endcase
  endfunction

  // One operation: start at E0, busy for N cycles, done in the cycle after E0+N
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
    logic [17:0] o;
    int n;
    n = (w / 2) * (w / 2);
    @(negedge clk);
    drive(w, 1'b1, a, b);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) drive(w, 1'b0, 8'h00, 8'h00);
      o = obs(w);
      chk({tag, "_busy"}, 32'(o[17]), 32'd1);
      chk({tag, "_nodone"}, 32'(o[16]), 32'd0);
    end
    @(negedge clk);
    o = obs(w);
    chk({tag, "_done"}, 32'(o[16]), 32'd1);
    chk({tag, "_idle"}, 32'(o[17]), 32'd0);
    chk({tag, "_prod"}, 32'(o[15:0]), 32'(exp));
  endtask

  logic [1:0] ea [4];
  logic [1:0] eb [4];
  logic [7:0] ra, rb, mask;

  initial begin
    ea = '{2'b10, 2'b10, 2'b01, 2'b01};
    eb = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b0;
    drive(2, 1'b0, 8'h00, 8'h00);
    drive(4, 1'b0, 8'h00, 8'h00);
    drive(8, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_prod", 32'(prod4), 32'd0);
    chk("rst_ma", 32'(ma4), 32'd3);
    chk("rst_mb", 32'(mb4), 32'd3);

    run_op(4, 8'h0F, 8'h0F, 16'h00E1, "f_x_f");

    // Digit bus sequence for 9 x 6
    @(negedge clk);
    drive(4, 1'b1, 8'h09, 8'h06);
    chk("idle_ma", 32'(ma4), 32'd3);
    chk("idle_mb", 32'(mb4), 32'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) drive(4, 1'b0, 8'h00, 8'h00);
      chk($sformatf("seq_ma%0d", k), 32'(ma4), 32'(ea[k]));
      chk($sformatf("seq_mb%0d", k), 32'(mb4), 32'(eb[k]));
    end
    @(negedge clk);
    chk("seq_done", 32'(done4), 32'd1);
    chk("seq_prod", 32'(prod4), 32'h36);
    chk("seq_ma_end", 32'(ma4), 32'd3);
    chk("seq_mb_end", 32'(mb4), 32'd3);

    // Start held high; op_a changes mid-run; back-to-back without bubble
    @(negedge clk);
    drive(4, 1'b1, 8'h0D, 8'h0B);
    @(negedge clk);
    chk("b2b_busy1", 32'(busy4), 32'd1);
    @(negedge clk);
    drive(4, 1'b1, 8'h03, 8'h0B);
    chk("b2b_busy2", 32'(busy4), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_nodone", 32'(done4), 32'd0);
    @(negedge clk);
    chk("b2b_done1", 32'(done4), 32'd1);
    chk("b2b_prod1", 32'(prod4), 32'h8F);
    chk("b2b_idle1", 32'(busy4), 32'd0);
    @(negedge clk);
    drive(4, 1'b0, 8'h00, 8'h00);
    chk("b2b_nobubble", 32'(busy4), 32'd1);
    chk("b2b_hold", 32'(prod4), 32'h8F);
    repeat (3) @(negedge clk);
    chk("b2b_hold2", 32'(prod4), 32'h8F);
    @(negedge clk);
    chk("b2b_done2", 32'(done4), 32'd1);
    chk("b2b_prod2", 32'(prod4), 32'h21);

    run_op(4, 8'h00, 8'h0A, 16'h0000, "zero");
    run_op(4, 8'h05, 8'h03, 16'h000F, "five3");

    // Asynchronous reset in RUN cycle 2
    @(negedge clk);
    drive(4, 1'b1, 8'h0F, 8'h0F);
    @(negedge clk);
    drive(4, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy4), 32'd0);
    chk("arst_done", 32'(done4), 32'd0);
    chk("arst_prod", 32'(prod4), 32'd0);
    chk("arst_ma", 32'(ma4), 32'd3);
    chk("arst_mb", 32'(mb4), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("arst_nodone%0d", k), 32'(done4), 32'd0);
    end
    run_op(4, 8'h02, 8'h03, 16'h0006, "after_rst");

    run_op(2, 8'h03, 8'h03, 16'h0009, "w2_3x3");
    run_op(8, 8'hFF, 8'hFF, 16'hFE01, "w8_max");

    // Sweep against a*b for each width
    foreach (ea[w]) begin end
    for (int wi = 0; wi < 3; wi++) begin
      int w;
      w = (wi == 0) ? 2 : ((wi == 1) ? 4 : 8);
      mask = 8'((16'd1 << w) - 16'd1);
      for (int t = 0; t < 6; t++) begin
        ra = 8'($urandom) & mask;
        rb = 8'($urandom) & mask;
        run_op(w, ra, rb, 16'(ra) * 16'(rb), $sformatf("sweep_w%0d_%0d", w, t));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
